// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight register writes, registers per-source EX forward selects, raises load-use stalls
module fwd_scoreboard #(
  parameter int REG_AW = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int ZERO_REG = 1,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_freeze,
  input  logic                      i_flush,
  input  logic                      i_id_valid,
  input  logic                      i_id_regwrite,
  input  logic                      i_id_isload,
  input  logic [REG_AW-1:0]         i_id_rd,
  input  logic [NUM_SRC-1:0]        i_id_src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] i_id_src,
  output logic                      o_stall,
  output logic [NUM_SRC*SW-1:0]     o_fwd_sel
);
  // The oldest stage only writes the register file and is never forwarded, so it is not stored.
  localparam int NE = (DEPTH > 1) ? DEPTH - 1 : 1;
  logic [NE-1:0]         r_v;
  logic [NE-1:0]         r_ld;
  logic [REG_AW-1:0]     r_rd [NE];
  logic [NUM_SRC*SW-1:0] r_fwd_sel;
  logic [NUM_SRC*SW-1:0] w_sel;
  logic [NUM_SRC-1:0]    w_hazard;
  logic                  w_advance;
  // Scan oldest to youngest so the youngest matching stage overwrites and wins.
  always_comb begin
    w_sel = '0;
    w_hazard = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = DEPTH - 2; k >= 0; k--)
        if (r_v[k] && i_id_src_valid[i] && r_rd[k] == i_id_src[i*REG_AW +: REG_AW] &&
            !(ZERO_REG != 0 && i_id_src[i*REG_AW +: REG_AW] == '0)) begin
          w_sel[i*SW +: SW] = SW'(k + 1);
          w_hazard[i] = r_ld[k] && (k + 1 < LOAD_AVAIL);
        end
  end
  assign o_stall = !i_flush && i_id_valid && |w_hazard;
  assign w_advance = !i_flush && !o_stall;
  assign o_fwd_sel = r_fwd_sel;
  // Age entries every unfrozen cycle; only an advancing valid ID instruction enters as a writer.
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      r_v <= '0;
      r_fwd_sel <= '0;
    end else if (!i_freeze) begin
      for (int k = NE - 1; k > 0; k--) begin
        r_v[k] <= r_v[k-1];
        r_ld[k] <= r_ld[k-1];
        r_rd[k] <= r_rd[k-1];
      end
      r_v[0] <= w_advance && i_id_valid && i_id_regwrite;
      r_ld[0] <= i_id_isload;
      r_rd[0] <= i_id_rd;
      r_fwd_sel <= (w_advance && i_id_valid) ? w_sel : '0;
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scoreboard bench for two configurations of fwd_scoreboard
module tb_fwd_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  logic id_valid = 1'b0;
  logic id_regwrite = 1'b0;
  logic id_isload = 1'b0;
  logic [3:0] id_rd = '0;
  logic [1:0] id_src_valid = '0;
  logic [7:0] id_src = '0;
  logic stall_a, stall_b;
  logic [3:0] sel_a, sel_b;
  logic mode = 1'b0;
  logic [3:0] exp_q [$];
  string tag_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_scoreboard u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_freeze(freeze), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_regwrite(id_regwrite), .i_id_isload(id_isload),
    .i_id_rd(id_rd), .i_id_src_valid(id_src_valid), .i_id_src(id_src),
    .o_stall(stall_a), .o_fwd_sel(sel_a)
  );

  fwd_scoreboard #(.DEPTH(4), .LOAD_AVAIL(3)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_freeze(freeze), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_regwrite(id_regwrite), .i_id_isload(id_isload),
    .i_id_rd(id_rd), .i_id_src_valid(id_src_valid), .i_id_src(id_src),
    .o_stall(stall_b), .o_fwd_sel(sel_b)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_sel();
    if (exp_q.size() > 0) check({tag_q.pop_front(), "_sel"}, 8'(mode ? sel_b : sel_a), 8'(exp_q.pop_front()));
  endtask

  task automatic drive(input string tag, input logic fz, fl, v, rw, ld, input logic [3:0] rd,
                       input logic [1:0] sv, input logic [3:0] s0, s1,
                       input logic es, input logic [1:0] e0, e1);
    @(negedge clk);
    pop_sel();
    rst = 1'b1;
    freeze = fz;
    flush = fl;
    id_valid = v;
    id_regwrite = rw;
    id_isload = ld;
    id_rd = rd;
    id_src_valid = sv;
    id_src = {s1, s0};
    #1;
    check({tag, "_stall"}, 8'(mode ? stall_b : stall_a), 8'(es));
    exp_q.push_back({e1, e0});
    tag_q.push_back(tag);
  endtask

  task automatic do_reset(input logic m);
    @(negedge clk);
    pop_sel();
    mode = m;
    rst = 1'b0;
    freeze = 1'b0;
    flush = 1'b0;
    id_valid = 1'b1;
    id_regwrite = 1'b0;
    id_isload = 1'b0;
    id_src_valid = 2'b01;
    id_src = {4'd0, 4'd15};
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back(4'd0);
    tag_q.push_back("reset");
  endtask

  initial begin
    do_reset(1'b0);
    //      tag          fz fl v  rw ld rd  sv     s0  s1  es e0 e1
    drive("alu_add",     0, 0, 1, 1, 0, 1,  2'b00, 0,  0,  0, 0, 0);
    drive("alu_b2b",     0, 0, 1, 0, 0, 0,  2'b01, 1,  5,  0, 1, 0);
    drive("nop1",        0, 0, 0, 0, 0, 0,  2'b00, 0,  0,  0, 0, 0);
    drive("d2_add",      0, 0, 1, 1, 0, 2,  2'b00, 0,  0,  0, 0, 0);
    drive("d2_nop",      0, 0, 0, 0, 0, 0,  2'b00, 0,  0,  0, 0, 0);
    drive("d2_use",      0, 0, 1, 0, 0, 0,  2'b10, 7,  2,  0, 0, 2);
    drive("yw_add_a",    0, 0, 1, 1, 0, 3,  2'b00, 0,  0,  0, 0, 0);
    drive("yw_add_b",    0, 0, 1, 1, 0, 3,  2'b00, 0,  0,  0, 0, 0);
    drive("yw_both",     0, 0, 1, 0, 0, 0,  2'b11, 3,  3,  0, 1, 1);
    drive("add_r6",      0, 0, 1, 1, 0, 6,  2'b00, 0,  0,  0, 0, 0);
    drive("oldest_nofw", 0, 0, 1, 1, 0, 8,  2'b11, 6,  3,  0, 1, 0);
    drive("split_src",   0, 0, 1, 0, 0, 0,  2'b11, 8,  6,  0, 1, 2);
    drive("ld_r0",       0, 0, 1, 1, 1, 0,  2'b00, 0,  0,  0, 0, 0);
    drive("zero_src",    0, 0, 1, 0, 0, 0,  2'b11, 0,  0,  0, 0, 0);
    drive("ld_r9",       0, 0, 1, 1, 1, 9,  2'b00, 0,  0,  0, 0, 0);
    drive("unused_src",  0, 0, 1, 0, 0, 0,  2'b00, 9,  9,  0, 0, 0);
    drive("ld_dist2",    0, 0, 1, 0, 0, 0,  2'b01, 9,  0,  0, 2, 0);
    drive("ld_r4",       0, 0, 1, 1, 1, 4,  2'b00, 0,  0,  0, 0, 0);
    drive("lu_stall",    0, 0, 1, 0, 0, 0,  2'b01, 4,  0,  1, 0, 0);
    drive("lu_fwd",      0, 0, 1, 0, 0, 0,  2'b01, 4,  0,  0, 2, 0);
    drive("add_r11",     0, 0, 1, 1, 0, 11, 2'b00, 0,  0,  0, 0, 0);
    drive("ld_r10",      0, 0, 1, 1, 1, 10, 2'b01, 11, 0,  0, 1, 0);
    drive("frz1",        1, 0, 1, 0, 0, 0,  2'b01, 10, 0,  1, 1, 0);
    drive("frz2",        1, 0, 1, 0, 0, 0,  2'b01, 10, 0,  1, 1, 0);
    drive("frz3",        1, 0, 1, 0, 0, 0,  2'b01, 10, 0,  1, 1, 0);
    drive("frz_rel",     0, 0, 1, 0, 0, 0,  2'b01, 10, 0,  1, 0, 0);
    drive("frz_fwd",     0, 0, 1, 1, 0, 13, 2'b01, 10, 0,  0, 2, 0);
    drive("ld_r12",      0, 0, 1, 1, 1, 12, 2'b01, 13, 0,  0, 1, 0);
    drive("flush",       0, 1, 1, 1, 0, 14, 2'b01, 12, 0,  0, 0, 0);
    drive("post_flush",  0, 0, 1, 0, 0, 0,  2'b11, 14, 12, 0, 0, 2);
    drive("ld_r15",      0, 0, 1, 1, 1, 15, 2'b00, 0,  0,  0, 0, 0);
    do_reset(1'b0);
    drive("post_rst",    0, 0, 1, 0, 0, 0,  2'b01, 15, 0,  0, 0, 0);
    drive("add_r1",      0, 0, 1, 1, 0, 1,  2'b00, 0,  0,  0, 0, 0);
    drive("invalid_id",  0, 0, 0, 1, 0, 2,  2'b01, 1,  0,  0, 0, 0);
    drive("after_inval", 0, 0, 1, 0, 0, 0,  2'b11, 2,  1,  0, 0, 2);
    do_reset(1'b1);
    drive("b_ld_r4",     0, 0, 1, 1, 1, 4,  2'b00, 0,  0,  0, 0, 0);
    drive("b_stall1",    0, 0, 1, 0, 0, 0,  2'b01, 4,  0,  1, 0, 0);
    drive("b_stall2",    0, 0, 1, 0, 0, 0,  2'b01, 4,  0,  1, 0, 0);
    drive("b_fwd3",      0, 0, 1, 0, 0, 0,  2'b01, 4,  0,  0, 3, 0);
    drive("b_nop",       0, 0, 0, 0, 0, 0,  2'b00, 0,  0,  0, 0, 0);
    @(negedge clk);
    pop_sel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
